// File: rtl/psram_burst_responder_if.sv
// PSRAM bus between a burst controller (master) and the emulated device (slave).
// Carries the address/control strobes, both data directions and the wait line.
interface psram_if #(
    parameter int data_width          = 16,
    parameter int psram_address_width = 23
);
    logic [psram_address_width-1:0] psram_adr;
    logic [data_width-1:0]          psram_dat_i;
    logic [data_width-1:0]          psram_dat_o;
    logic                           psram_dat_oe;
    logic                           psram_ce_n;
    logic                           psram_adv_n;
    logic                           psram_oe_n;
    logic                           psram_we_n;
    logic                           psram_wait;

    modport master (
        output psram_adr,
        output psram_dat_i,
        output psram_ce_n,
        output psram_adv_n,
        output psram_oe_n,
        output psram_we_n,
        input  psram_dat_o,
        input  psram_dat_oe,
        input  psram_wait
    );

    modport slave (
        input  psram_adr,
        input  psram_dat_i,
        input  psram_ce_n,
        input  psram_adv_n,
        input  psram_oe_n,
        input  psram_we_n,
        output psram_dat_o,
        output psram_dat_oe,
        output psram_wait
    );
endinterface

// File: rtl/psram_burst_responder.sv
// Burst PSRAM device emulator: latches a start address, waits a fixed access
// latency, then streams one word per clock to/from an internal memory array.
module psram_burst_responder #(
    parameter int data_width          = 16,
    parameter int psram_address_width = 23,
    parameter int mem_address_width   = 8,
    parameter int access_latency      = 2,
    parameter int max_burst           = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    psram_if.slave     bus,
    output logic       busy,
    output logic [5:0] word_count
);

    localparam int LAT_W = (access_latency > 1) ? $clog2(access_latency) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(access_latency - 1);
    localparam logic [5:0]       BURST_END = 6'(max_burst - 1);

    typedef enum logic [1:0] {
        IDLE,
        LATENCY,
        DATA,
        EXHAUSTED
    } state_t;

    state_t                         state_q;
    state_t                         state_d;
    logic [LAT_W-1:0]               lat_q;
    logic [mem_address_width-1:0]   base_q;
    logic                           wr_q;
    logic [mem_address_width-1:0]   cur;
    logic                           addr_cyc;
    logic                           xfer;
    logic                           rd_drive;
    logic                           unused_adr_hi;

    logic [data_width-1:0] mem [0:(1 << mem_address_width) - 1];

    // Burst addresses wrap silently inside the internal array.
    function automatic logic [mem_address_width-1:0] wrap_addr(
        input logic [mem_address_width-1:0] base,
        input logic [5:0]                   k
    );
        return base + mem_address_width'(k);
    endfunction

    assign unused_adr_hi = ^bus.psram_adr;

    assign addr_cyc = ~bus.psram_ce_n & ~bus.psram_adv_n;
    // A word moves only in a plain DATA cycle: deselect, restart and reset all pre-empt it.
    assign xfer     = (state_q == DATA) & ~rst_i & ~bus.psram_ce_n & bus.psram_adv_n;
    assign cur      = wrap_addr(base_q, word_count);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.psram_ce_n) begin
            state_d = IDLE;
        end else if (!bus.psram_adv_n) begin
            state_d = LATENCY;
        end else begin
            unique case (state_q)
                LATENCY:   if (lat_q == LAT_LAST) state_d = DATA;
                DATA:      if (word_count == BURST_END) state_d = EXHAUSTED;
                IDLE:      state_d = IDLE;
                EXHAUSTED: state_d = EXHAUSTED;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy             = (state_q != IDLE);
        bus.psram_wait   = (state_q == LATENCY) || (state_q == EXHAUSTED);
        rd_drive         = xfer & ~wr_q & ~bus.psram_oe_n;
        bus.psram_dat_oe = rd_drive;
        bus.psram_dat_o  = rd_drive ? mem[cur] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lat_q      <= '0;
            word_count <= '0;
        end else if (addr_cyc) begin
            lat_q      <= '0;
            word_count <= '0;
        end else begin
            if (state_q == LATENCY) begin
                lat_q <= lat_q + LAT_W'(1);
            end
            if (xfer) begin
                word_count <= word_count + 6'd1;
            end
        end
    end

    // Burst context and array contents survive reset; only the control path is cleared.
    always_ff @(posedge clk_i) begin
        if (addr_cyc && !rst_i) begin
            base_q <= bus.psram_adr[mem_address_width-1:0];
            wr_q   <= ~bus.psram_we_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (xfer && wr_q) begin
            mem[cur] <= bus.psram_dat_i;
        end
    end

endmodule

// File: tb/tb_psram_burst_responder.sv
// Directed bench for psram_burst_responder: read data is checked by a
// scoreboard monitor, status lines are checked cycle by cycle in the stimulus.
module tb_psram_burst_responder;

    localparam int DW   = 16;
    localparam int AW   = 23;
    localparam int MAW  = 8;
    localparam int LAT  = 2;
    localparam int MAXB = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [5:0] word_count;

    psram_if #(.data_width(DW), .psram_address_width(AW)) bus ();

    psram_burst_responder #(
        .data_width(DW),
        .psram_address_width(AW),
        .mem_address_width(MAW),
        .access_latency(LAT),
        .max_burst(MAXB)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus),
        .busy(busy),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] d;
    } sb_entry_t;

    sb_entry_t sb[$];
    sb_entry_t e;
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every driven read word must match the head of the scoreboard, in the promised cycle.
    always @(negedge clk) begin
        if (bus.psram_dat_oe === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: driven 0x%0h at cycle %0d, expected no drive",
                         bus.psram_dat_o, cyc);
            end else begin
                e = sb.pop_front();
                chk("rd_cycle", cyc, e.cyc);
                chk("rd_data", bus.psram_dat_o, e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_cycle(input logic [22:0] a, input bit wr);
        bus.psram_ce_n  = 1'b0;
        bus.psram_adv_n = 1'b0;
        bus.psram_adr   = a;
        bus.psram_we_n  = ~wr;
        bus.psram_oe_n  = 1'b0;
        tick();
    endtask

    task automatic lat_phase();
        for (int i = 0; i < LAT; i++) begin
            bus.psram_adv_n = 1'b1;
            #2;
            chk("lat_wait", bus.psram_wait, 1'b1);
            chk("lat_busy", busy, 1'b1);
            tick();
        end
    endtask

    task automatic wr_word(input logic [15:0] d, input int exp_wc);
        bus.psram_adv_n = 1'b1;
        bus.psram_dat_i = d;
        #2;
        chk("wr_wait", bus.psram_wait, 1'b0);
        chk("wr_wc", word_count, exp_wc);
        tick();
    endtask

    task automatic rd_word(input logic [15:0] d, input bit oe, input bit exp_wait, input int exp_wc);
        bus.psram_adv_n = 1'b1;
        bus.psram_oe_n  = ~oe;
        if (oe && !exp_wait) sb.push_back('{cyc: cyc, d: d});
        #2;
        chk("rd_wait", bus.psram_wait, exp_wait);
        chk("rd_wc", word_count, exp_wc);
        tick();
    endtask

    task automatic end_burst();
        bus.psram_ce_n  = 1'b1;
        bus.psram_adv_n = 1'b1;
        bus.psram_oe_n  = 1'b1;
        bus.psram_we_n  = 1'b1;
        tick();
    endtask

    task automatic write_burst(input logic [22:0] a, input logic [15:0] d0, input int n);
        addr_cycle(a, 1'b1);
        lat_phase();
        for (int k = 0; k < n; k++) wr_word(d0 + 16'(k), k);
        end_burst();
    endtask

    task automatic read_seq(input logic [22:0] a, input logic [15:0] d0, input int n);
        addr_cycle(a, 1'b0);
        lat_phase();
        for (int k = 0; k < n; k++) rd_word(d0 + 16'(k), 1'b1, 1'b0, k);
        end_burst();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.psram_ce_n  = 1'b1;
        bus.psram_adv_n = 1'b1;
        bus.psram_oe_n  = 1'b1;
        bus.psram_we_n  = 1'b1;
        bus.psram_adr   = '0;
        bus.psram_dat_i = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_dat_o", bus.psram_dat_o, 16'h0);
        chk("rst_oe", bus.psram_dat_oe, 1'b0);
        chk("rst_wait", bus.psram_wait, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wc", word_count, 6'd0);

        // Write burst at 0x10, then read it back with exact cycle placement.
        write_burst(23'h10, 16'hA000, 4);
        chk("wr_idle_wc", word_count, 6'd4);
        chk("wr_idle_busy", busy, 1'b0);
        read_seq(23'h10, 16'hA000, 4);

        // Read with oe_n high: words counted but never driven.
        addr_cycle(23'h10, 1'b0);
        lat_phase();
        rd_word(16'h0, 1'b0, 1'b0, 0);
        rd_word(16'h0, 1'b0, 1'b0, 1);
        end_burst();
        chk("nodrive_wc", word_count, 6'd2);

        // Address wrap at the top of the array; upper psram_adr bits ignored.
        write_burst(23'h7FFF_FE, 16'hBEE0, 4);
        read_seq(23'h0000FE, 16'hBEE0, 2);
        read_seq(23'h000000, 16'hBEE2, 2);

        // Exhaustion: 32-word write, then a read held for 40 data cycles.
        write_burst(23'h20, 16'hC000, MAXB);
        chk("full_wc", word_count, 6'd32);
        addr_cycle(23'h20, 1'b0);
        lat_phase();
        for (int k = 0; k < 40; k++) begin
            if (k < MAXB) rd_word(16'hC000 + 16'(k), 1'b1, 1'b0, k);
            else          rd_word(16'h0, 1'b1, 1'b1, MAXB);
        end
        end_burst();
        chk("exh_idle_wc", word_count, 6'd32);

        // Abort/restart on the third data cycle of a write.
        write_burst(23'h50, 16'h5550, 4);
        addr_cycle(23'h50, 1'b1);
        lat_phase();
        wr_word(16'hD000, 0);
        wr_word(16'hD001, 1);
        bus.psram_dat_i = 16'hD002;
        addr_cycle(23'h40, 1'b1);
        lat_phase();
        wr_word(16'hE000, 0);
        wr_word(16'hE001, 1);
        end_burst();
        addr_cycle(23'h50, 1'b0);
        lat_phase();
        rd_word(16'hD000, 1'b1, 1'b0, 0);
        rd_word(16'hD001, 1'b1, 1'b0, 1);
        rd_word(16'h5552, 1'b1, 1'b0, 2);
        rd_word(16'h5553, 1'b1, 1'b0, 3);
        end_burst();
        read_seq(23'h40, 16'hE000, 2);

        // Reset asserted on data cycle 1 of a write.
        write_burst(23'h60, 16'h6660, 4);
        addr_cycle(23'h60, 1'b1);
        lat_phase();
        wr_word(16'h7000, 0);
        bus.psram_dat_i = 16'h7001;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.psram_ce_n  = 1'b1;
        bus.psram_adv_n = 1'b1;
        #2;
        chk("mrst_dat_o", bus.psram_dat_o, 16'h0);
        chk("mrst_oe", bus.psram_dat_oe, 1'b0);
        chk("mrst_wait", bus.psram_wait, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_wc", word_count, 6'd0);
        tick();
        addr_cycle(23'h60, 1'b0);
        lat_phase();
        rd_word(16'h7000, 1'b1, 1'b0, 0);
        rd_word(16'h6661, 1'b1, 1'b0, 1);
        rd_word(16'h6662, 1'b1, 1'b0, 2);
        rd_word(16'h6663, 1'b1, 1'b0, 3);
        end_burst();
        read_seq(23'h10, 16'hA000, 4);

        tick();
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
